// File: rtl/tube_mmio_ctrl.sv
// MMIO front end for the 8-digit seven-segment driver: holds DATA/CTRL and
// optionally converts the stored value to packed BCD with a double-dabble engine.
module tube_mmio_ctrl #(
    parameter int unsigned CONV_BITS   = 27,
    parameter logic [31:0] BCD_MAX     = 32'd99999999,
    parameter logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        io_write,
    input  logic        io_read,
    input  logic        tube_sel,
    input  logic [1:0]  reg_off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] disp_num,
    output logic        disp_en,
    output logic        busy
);

    localparam int unsigned BCD_W  = 32;
    localparam int unsigned DIGITS = BCD_W / 4;
    localparam int unsigned SH_W   = BCD_W + CONV_BITS;
    localparam int unsigned CNT_W  = $clog2(CONV_BITS + 1);

    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_CTRL = 2'd1;
    localparam logic [1:0] OFF_DISP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       raw;
    logic              en;
    logic              bcd;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;
    logic [SH_W-1:0]   sh;
    logic [SH_W-1:0]   sh_adj;
    logic [SH_W-1:0]   sh_next;

    logic              wr_data;
    logic              wr_ctrl;
    logic              start;
    logic              abort;
    logic [31:0]       start_val;

    // Write decode; a conversion starts on a DATA write in BCD mode or on bcd 0->1.
    always_comb begin
        wr_data   = io_write & tube_sel & (reg_off == OFF_DATA);
        wr_ctrl   = io_write & tube_sel & (reg_off == OFF_CTRL);
        start     = (wr_data & bcd) | (wr_ctrl & ~bcd & wdata[1]);
        abort     = wr_ctrl & bcd & ~wdata[1];
        start_val = wr_data ? wdata : raw;
    end

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh[CONV_BITS + 4*i +: 4] >= 4'd5) begin
                sh_adj[CONV_BITS + 4*i +: 4] = sh[CONV_BITS + 4*i +: 4] + 4'd3;
            end
        end
        sh_next = {sh_adj[SH_W-2:0], 1'b0};
    end

    // Register file and conversion FSM; restart and abort take priority over the FSM step.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            raw      <= '0;
            en       <= 1'b0;
            bcd      <= 1'b0;
            ovf      <= 1'b0;
            cnt      <= '0;
            sh       <= '0;
            disp_num <= '0;
            disp_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (wr_data) begin
                raw <= wdata;
            end
            if (wr_ctrl) begin
                en      <= wdata[0];
                bcd     <= wdata[1];
                disp_en <= wdata[0];
            end

            if (start) begin
                sh    <= SH_W'(start_val[CONV_BITS-1:0]);
                ovf   <= (start_val > BCD_MAX);
                cnt   <= '0;
                busy  <= 1'b1;
                state <= CONV;
            end else if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                cnt      <= '0;
                disp_num <= raw;
            end else if (wr_data) begin
                disp_num <= wdata;
            end else begin
                case (state)
                    CONV: begin
                        sh  <= sh_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(CONV_BITS - 1)) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        disp_num <= ovf ? OVF_PATTERN : sh[SH_W-1 -: BCD_W];
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Load data is combinational and independent of io_read.
    always_comb begin
        case (reg_off)
            OFF_DATA: rdata = raw;
            OFF_CTRL: rdata = {29'b0, busy, bcd, en};
            OFF_DISP: rdata = disp_num;
            default:  rdata = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_tube_mmio_ctrl.sv
// Scoreboard bench for tube_mmio_ctrl: stimulus queues expected disp_num updates
// with their edge number, a monitor pops and checks each observed change.
module tb_tube_mmio_ctrl;

    logic        clock = 1'b0;
    logic        rst;
    logic        io_write;
    logic        io_read;
    logic        tube_sel;
    logic [1:0]  reg_off;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] disp_num;
    logic        disp_en;
    logic        busy;

    typedef struct {
        logic [31:0] val;
        int          cyc;   // -1: timing not checked
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] prev_disp = 32'h0;

    tube_mmio_ctrl dut (
        .clock    (clock),
        .rst      (rst),
        .io_write (io_write),
        .io_read  (io_read),
        .tube_sel (tube_sel),
        .reg_off  (reg_off),
        .wdata    (wdata),
        .rdata    (rdata),
        .disp_num (disp_num),
        .disp_en  (disp_en),
        .busy     (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every change of disp_num must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (disp_num !== prev_disp) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL disp_unexpected: got %h at edge %0d expected no update", disp_num, cyc);
                end else begin
                    e = sb.pop_front();
                    check("disp_val", disp_num, e.val);
                    if (e.cyc >= 0) check("disp_edge", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_disp = disp_num;
        end
    end

    task automatic wr(input logic [1:0] off, input logic [31:0] data,
                      input bit push, input logic [31:0] exp_val, input int lat);
        @(negedge clock);
        io_write = 1'b1; tube_sel = 1'b1; reg_off = off; wdata = data;
        if (push) sb.push_back('{exp_val, cyc + 1 + lat});
        @(negedge clock);
        io_write = 1'b0; tube_sel = 1'b0; reg_off = 2'd0;
    endtask

    task automatic rd(input logic [1:0] off, input string name, input logic [31:0] exp);
        reg_off = off;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'h0);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; io_write = 1'b0; io_read = 1'b0; tube_sel = 1'b0;
        reg_off = 2'd0; wdata = 32'h0;
        repeat (2) @(negedge clock);
        check("rst_disp", disp_num, 32'h0);
        check("rst_en", 32'(disp_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rd(2'd0, "rst_raw", 32'h0);
        rd(2'd1, "rst_ctrl", 32'h0);
        @(negedge clock);
        rst = 1'b1;

        // Hex mode: 1-edge latency, busy stays low.
        wr(2'd0, 32'h1234_ABCD, 1, 32'h1234_ABCD, 0);
        check("hex_busy", 32'(busy), 32'h0);
        rd(2'd0, "hex_raw", 32'h1234_ABCD);

        // Unselected and reserved-offset writes have no effect.
        @(negedge clock);
        io_write = 1'b1; tube_sel = 1'b0; reg_off = 2'd0; wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        io_write = 1'b0;
        rd(2'd0, "nosel_raw", 32'h1234_ABCD);
        wr(2'd2, 32'h5555_5555, 0, 32'h0, 0);
        wr(2'd3, 32'h6666_6666, 0, 32'h0, 0);
        rd(2'd3, "rsvd_read", 32'h0);
        rd(2'd2, "disp_read", 32'h1234_ABCD);

        // bcd 0->1 starts converting raw; the DATA write right after restarts it.
        wr(2'd1, 32'h3, 0, 32'h0, 0);
        check("ctrl_en", 32'(disp_en), 32'h1);
        wr(2'd0, 32'd12345678, 1, 32'h1234_5678, 28);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("busy_cycles", 32'(n), 32'd28);
        rd(2'd2, "bcd_rdata", 32'h1234_5678);
        rd(2'd1, "bcd_ctrl", 32'h3);

        // Overflow boundary.
        wr(2'd0, 32'd100000000, 1, 32'hEEEE_EEEE, 28);
        wait_idle();
        wr(2'd0, 32'd99999999, 1, 32'h9999_9999, 28);
        wait_idle();

        // Latest write wins; 5 must never reach disp_num.
        wr(2'd0, 32'd5, 0, 32'h0, 0);
        repeat (8) @(negedge clock);
        wr(2'd0, 32'd42, 1, 32'h0000_0042, 28);
        wait_idle();

        // Abort into hex mode mid-conversion.
        wr(2'd0, 32'd255, 0, 32'h0, 0);
        repeat (5) @(negedge clock);
        check("abort_pre_busy", 32'(busy), 32'h1);
        wr(2'd1, 32'h1, 1, 32'h0000_00FF, 0);
        check("abort_busy", 32'(busy), 32'h0);
        rd(2'd1, "abort_ctrl", 32'h1);

        // Reset in the middle of a conversion.
        wr(2'd1, 32'h3, 0, 32'h0, 0);
        repeat (12) @(negedge clock);
        check("midrst_busy", 32'(busy), 32'h1);
        sb.push_back('{32'h0, -1});
        #2 rst = 1'b0;
        #1;
        check("midrst_disp", disp_num, 32'h0);
        check("midrst_busy0", 32'(busy), 32'h0);
        check("midrst_en", 32'(disp_en), 32'h0);
        repeat (2) @(negedge clock);
        rst = 1'b1;
        rd(2'd1, "post_rst_ctrl", 32'h0);
        rd(2'd0, "post_rst_raw", 32'h0);
        repeat (40) @(negedge clock);
        check("post_rst_disp", disp_num, 32'h0);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
